// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the two-master SDRAM arbiter.
// Imported by the arbiter top and by its read-ID FIFO.
package sdram_arb_pkg;

    localparam int NUM_MASTERS  = 2;
    localparam int DEF_ADDR_W   = 25;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_BE_W     = DEF_DATA_W / 8;
    localparam int DEF_MAX_PEND = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    function automatic arb_state_t grant_state(input master_id_t id);
        return id ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/sdram_arb_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads; the head names the
// master that owns the next read beat returned by the SDRAM controller.
module sdram_arb_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_PEND,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             push,
    input  logic             pop,
    input  master_id_t       din,
    output master_id_t       dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    master_id_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        dout    = mem[rd_ptr];
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter letting the CPU data master (m0) and a hardware client
// (m1) share one Avalon-MM SDRAM slave; read beats return via an ID FIFO.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BE_W     = DEF_BE_W,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [ADDR_W-1:0]           m0_address,
    input  logic                        m0_read,
    input  logic                        m0_write,
    input  logic [DATA_W-1:0]           m0_writedata,
    input  logic [BE_W-1:0]             m0_byteenable,
    output logic                        m0_waitrequest,
    output logic [DATA_W-1:0]           m0_readdata,
    output logic                        m0_readdatavalid,
    input  logic [ADDR_W-1:0]           m1_address,
    input  logic                        m1_read,
    input  logic                        m1_write,
    input  logic [DATA_W-1:0]           m1_writedata,
    input  logic [BE_W-1:0]             m1_byteenable,
    output logic                        m1_waitrequest,
    output logic [DATA_W-1:0]           m1_readdata,
    output logic                        m1_readdatavalid,
    output logic [ADDR_W-1:0]           s_address,
    output logic                        s_read,
    output logic                        s_write,
    output logic [DATA_W-1:0]           s_writedata,
    output logic [BE_W-1:0]             s_byteenable,
    input  logic                        s_waitrequest,
    input  logic [DATA_W-1:0]           s_readdata,
    input  logic                        s_readdatavalid,
    output logic [$clog2(MAX_PEND):0]   pend_count,
    output logic                        err_rdv_underflow,
    output arb_state_t                  arb_state
);

    arb_state_t state;
    master_id_t last_winner;
    master_id_t gnt_id;
    master_id_t fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       req0, req1, elig0, elig1;
    logic       granted, g_read, g_write, blocked, accept;

    // Handshake: a command is transferred on a cycle where s_read or s_write
    // is high and s_waitrequest is low; the granted master sees the same
    // waitrequest, the other master always sees 1.
    always_comb begin
        req0    = m0_read | m0_write;
        req1    = m1_read | m1_write;
        elig0   = req0 && !(m0_read && fifo_full);
        elig1   = req1 && !(m1_read && fifo_full);
        granted = (state != IDLE);
        gnt_id  = master_id_t'(state == GRANT1);

        g_read       = gnt_id ? m1_read       : m0_read;
        g_write      = gnt_id ? m1_write      : m0_write;
        s_address    = gnt_id ? m1_address    : m0_address;
        s_writedata  = gnt_id ? m1_writedata  : m0_writedata;
        s_byteenable = gnt_id ? m1_byteenable : m0_byteenable;

        // read+write together forwards only the read
        blocked = g_read && fifo_full;
        s_read  = granted && g_read && !fifo_full;
        s_write = granted && g_write && !g_read;
        accept  = (s_read || s_write) && !s_waitrequest;

        m0_waitrequest = (state == GRANT0) ? (s_waitrequest || blocked) : 1'b1;
        m1_waitrequest = (state == GRANT1) ? (s_waitrequest || blocked) : 1'b1;

        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
        m0_readdatavalid = s_readdatavalid && !fifo_empty && (fifo_dout == 1'b0);
        m1_readdatavalid = s_readdatavalid && !fifo_empty && (fifo_dout == 1'b1);

        arb_state = state;
    end

    // Grant only moves on acceptance, so the command is stable under stall.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state       <= IDLE;
            last_winner <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (elig0 && elig1) begin
                        state <= last_winner ? GRANT0 : GRANT1;
                    end else if (elig0) begin
                        state <= GRANT0;
                    end else if (elig1) begin
                        state <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (accept) begin
                        last_winner <= gnt_id;
                        if (gnt_id ? elig0 : elig1) begin
                            state <= grant_state(!gnt_id);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!(gnt_id ? req1 : req0)) begin
                        // a withdrawn request must not lock the slave port
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            err_rdv_underflow <= 1'b0;
        end else if (s_readdatavalid && fifo_empty) begin
            err_rdv_underflow <= 1'b1;
        end
    end

    sdram_arb_id_fifo #(
        .DEPTH (MAX_PEND)
    ) u_id_fifo (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .push          (accept && s_read),
        .pop           (s_readdatavalid),
        .din           (gnt_id),
        .dout          (fifo_dout),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .count         (pend_count)
    );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios, then randomized traffic
// scored against per-master command queues and an in-order read model.
`timescale 1ns/1ps
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    logic clk = 0;
    logic rst_n = 0;
    logic [1:0] m_read, m_write, m_wait, m_rdv;
    logic [24:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [3:0] m_be [2];
    logic [31:0] m0_rdata, m1_rdata;
    logic [24:0] s_address;
    logic s_read, s_write, s_wait, s_rdv;
    logic [31:0] s_writedata, s_rdata;
    logic [3:0] s_byteenable;
    logic [3:0] pend_count;
    logic err;
    arb_state_t dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_en = 0;
    bit slave_run = 0;
    int pend_model = 0;
    logic [62:0] exp_q0 [$];
    logic [62:0] exp_q1 [$];
    logic [32:0] exp_rd_q [$];
    logic [31:0] ret_q [$];

    always #10 clk = ~clk;

    sdram_arbiter dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .m0_address(m_addr[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
        .m0_writedata(m_wdata[0]), .m0_byteenable(m_be[0]),
        .m0_waitrequest(m_wait[0]), .m0_readdata(m0_rdata), .m0_readdatavalid(m_rdv[0]),
        .m1_address(m_addr[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
        .m1_writedata(m_wdata[1]), .m1_byteenable(m_be[1]),
        .m1_waitrequest(m_wait[1]), .m1_readdata(m1_rdata), .m1_readdatavalid(m_rdv[1]),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_wait), .s_readdata(s_rdata), .s_readdatavalid(s_rdv),
        .pend_count(pend_count), .err_rdv_underflow(err), .arb_state(dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_read = '0; m_write = '0; s_wait = 0; s_rdv = 0; s_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_wdata[i] = '0; m_be[i] = 4'hF;
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst_n = 1;
    endtask

    task automatic wait_accept(input int m, input int limit);
        bit ok = 0;
        for (int t = 0; t < limit; t++) begin
            @(negedge clk);
            if (!m_wait[m]) begin
                ok = 1;
                break;
            end
        end
        check($sformatf("accept_m%0d", m), 64'(ok), 64'd1);
        next_cycle();
    endtask

    task automatic run_master(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            int kind = $urandom_range(0, 15);
            logic rd = (kind < 7) || (kind == 15);
            logic wr = (kind >= 7);
            logic [24:0] a = {(m == 1), 24'($urandom)};
            logic [31:0] d = $urandom;
            logic [3:0] be = 4'($urandom_range(1, 15));
            if (m == 0) exp_q0.push_back({rd, wr & ~rd, a, d, be});
            else exp_q1.push_back({rd, wr & ~rd, a, d, be});
            m_read[m] = rd; m_write[m] = wr; m_addr[m] = a; m_wdata[m] = d; m_be[m] = be;
            wait_accept(m, 2000);
            m_read[m] = 0; m_write[m] = 0;
            repeat ($urandom_range(0, 2)) next_cycle();
        end
    endtask

    task automatic slave_loop();
        while (slave_run) begin
            next_cycle();
            s_wait = ($urandom_range(0, 3) == 0);
            if (ret_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                s_rdv = 1;
                s_rdata = ret_q.pop_front();
            end else begin
                s_rdv = 0;
                s_rdata = $urandom;
            end
        end
        s_rdv = 0;
        s_wait = 0;
    endtask

    // Scoreboard monitor: slave-side commands against issued commands,
    // returned beats against the in-order read model.
    always @(negedge clk) begin
        if (rand_en) begin
            logic [62:0] cmd;
            logic [32:0] rexp;
            logic [31:0] rdata;
            check("pend_count", 64'(pend_count), 64'(pend_model));
            if ((s_read || s_write) && !s_wait) begin
                cmd = {s_read, s_write, s_address, s_writedata, s_byteenable};
                if (s_address[24]) begin
                    if (exp_q1.size() == 0) fail("cmd_m1_unexpected");
                    else check("cmd_m1", 64'(cmd), 64'(exp_q1.pop_front()));
                end else begin
                    if (exp_q0.size() == 0) fail("cmd_m0_unexpected");
                    else check("cmd_m0", 64'(cmd), 64'(exp_q0.pop_front()));
                end
                if (s_read) begin
                    rdata = $urandom;
                    ret_q.push_back(rdata);
                    exp_rd_q.push_back({s_address[24], rdata});
                    pend_model++;
                end
            end
            if (s_rdv) begin
                if (exp_rd_q.size() == 0) begin
                    fail("rdv_unexpected");
                end else begin
                    rexp = exp_rd_q.pop_front();
                    check("rd_route", {30'd0, m_rdv, m_rdv[1] ? m1_rdata : m0_rdata},
                          {30'd0, rexp[32] ? 2'b10 : 2'b01, rexp[31:0]});
                    pend_model--;
                end
            end else begin
                check("no_spurious_rdv", 64'(m_rdv), 64'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_m;
        int ord [$];
        int r0, r1, acc;
        bit got_w;
        int exp_route [3] = '{0, 1, 0};

        // reset values
        rst_n = 0;
        idle_inputs();
        m_read = 2'b11;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_s_read", 64'(s_read), 0);
        check("rst_s_write", 64'(s_write), 0);
        check("rst_wait", 64'(m_wait), 64'b11);
        check("rst_rdv", 64'(m_rdv), 0);
        check("rst_pend", 64'(pend_count), 0);
        check("rst_err", 64'(err), 0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));

        // single m0 read, data returned three cycles after acceptance
        next_cycle();
        rst_n = 1; m_read = 2'b01; m_addr[0] = 25'h10;
        @(negedge clk);
        check("t1_idle_s_read", 64'(s_read), 0);
        check("t1_idle_wait", 64'(m_wait[0]), 1);
        next_cycle();
        @(negedge clk);
        check("t1_s_read", 64'(s_read), 1);
        check("t1_s_address", 64'(s_address), 64'h10);
        check("t1_m0_wait", 64'(m_wait[0]), 0);
        check("t1_state", 64'(dbg_state), 64'(GRANT0));
        next_cycle();
        m_read = 2'b00;
        @(negedge clk);
        check("t1_pend", 64'(pend_count), 1);
        check("t1_no_rdv_early", 64'(m_rdv), 0);
        next_cycle();
        next_cycle();
        s_rdv = 1; s_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("t1_rdv", 64'(m_rdv), 64'b01);
        check("t1_rdata", 64'(m0_rdata), 64'hDEADBEEF);
        next_cycle();
        s_rdv = 0;
        @(negedge clk);
        check("t1_rdv_once", 64'(m_rdv), 0);
        check("t1_pend_zero", 64'(pend_count), 0);

        // both masters write continuously: m0, m1, m0, m1
        do_reset();
        m_write = 2'b11; m_addr[0] = 25'h20; m_addr[1] = 25'h30;
        m_wdata[0] = 32'hA000_0000; m_wdata[1] = 32'hB000_0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("t2_idle_write", 64'(s_write), 0);
                next_cycle();
            end else begin
                exp_m = (k - 1) % 2;
                check($sformatf("t2_s_write_%0d", k), 64'(s_write), 1);
                check($sformatf("t2_wdata_%0d", k), 64'(s_writedata), 64'(m_wdata[exp_m]));
                check($sformatf("t2_gnt_wait_%0d", k), 64'(m_wait[exp_m]), 0);
                check($sformatf("t2_other_wait_%0d", k), 64'(m_wait[1 - exp_m]), 1);
                next_cycle();
                m_wdata[exp_m] = m_wdata[exp_m] + 1;
            end
        end
        m_write = 2'b00;

        // stall in GRANT1 with m0 waiting
        do_reset();
        m_write[1] = 1; m_addr[1] = 25'h55; m_wdata[1] = 32'h1111_5555; s_wait = 1;
        next_cycle();
        m_write[0] = 1; m_addr[0] = 25'h66; m_wdata[0] = 32'h2222_6666;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_addr", 64'(s_address), 64'h55);
            check("t3_stall_wait", 64'(m_wait), 64'b11);
            next_cycle();
        end
        s_wait = 0;
        @(negedge clk);
        check("t3_accept_m1", 64'(m_wait), 64'b01);
        next_cycle();
        m_write[1] = 0;
        @(negedge clk);
        check("t3_handoff_addr", 64'(s_address), 64'h66);
        check("t3_handoff_wait", 64'(m_wait[0]), 0);
        next_cycle();
        m_write[0] = 0;

        // fill the ID FIFO from m1, then check read gating
        do_reset();
        for (int i = 0; i < 8; i++) begin
            m_read[1] = 1; m_addr[1] = 25'(32'h100 + i);
            wait_accept(1, 10);
        end
        m_addr[1] = 25'h108;
        m_write[0] = 1; m_addr[0] = 25'h77; m_wdata[0] = 32'h7777_0000;
        got_w = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) check("t4_pend_full", 64'(pend_count), 8);
            check("t4_read_gated", 64'(s_read), 0);
            check("t4_m1_wait", 64'(m_wait[1]), 1);
            if (!m_wait[0] && s_write) got_w = 1;
            next_cycle();
            if (got_w) m_write[0] = 0;
        end
        check("t4_write_accepted", 64'(got_w), 1);
        s_rdv = 1; s_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("t4_pop_rdv", 64'(m_rdv), 64'b10);
        check("t4_pop_no_read", 64'(s_read), 0);
        next_cycle();
        s_rdv = 0;
        wait_accept(1, 6);
        m_read[1] = 0;
        @(negedge clk);
        check("t4_pend_refill", 64'(pend_count), 8);

        // interleaved reads m0, m1, m0 and their routed returns
        do_reset();
        m_read = 2'b11; m_addr[0] = 25'h200; m_addr[1] = 25'h300;
        r0 = 2; r1 = 1;
        ord.delete();
        for (int t = 0; t < 12 && ord.size() < 3; t++) begin
            @(negedge clk);
            acc = -1;
            if (m_read[0] && !m_wait[0]) acc = 0;
            else if (m_read[1] && !m_wait[1]) acc = 1;
            next_cycle();
            if (acc == 0) begin
                ord.push_back(0); r0--;
                if (r0 == 0) m_read[0] = 0; else m_addr[0] = m_addr[0] + 1;
            end else if (acc == 1) begin
                ord.push_back(1); r1--;
                if (r1 == 0) m_read[1] = 0;
            end
        end
        check("t5_accept_count", 64'(ord.size()), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5_order_%0d", i), 64'((ord.size() > i) ? ord[i] : -1), 64'(exp_route[i]));
        end
        for (int i = 0; i < 3; i++) begin
            s_rdv = 1; s_rdata = 32'hC0DE_0000 + i;
            @(negedge clk);
            check($sformatf("t5_route_%0d", i), 64'(m_rdv), (exp_route[i] == 1) ? 64'b10 : 64'b01);
            check($sformatf("t5_data_%0d", i), 64'(exp_route[i] == 1 ? m1_rdata : m0_rdata),
                  64'(32'hC0DE_0000 + i));
            next_cycle();
        end
        s_rdv = 0;

        // readdatavalid with empty FIFO, then reset during a grant
        s_rdv = 1; s_rdata = 32'h0000_0BAD;
        @(negedge clk);
        check("t6_no_rdv", 64'(m_rdv), 0);
        next_cycle();
        s_rdv = 0;
        @(negedge clk);
        check("t6_err_set", 64'(err), 1);
        check("t6_pend_zero", 64'(pend_count), 0);
        m_read[0] = 1; m_addr[0] = 25'h400; s_wait = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("t6_granted_read", 64'(s_read), 1);
        next_cycle();
        rst_n = 0;
        next_cycle();
        @(negedge clk);
        check("t6_rst_s_read", 64'(s_read), 0);
        check("t6_rst_wait", 64'(m_wait), 64'b11);
        check("t6_rst_err", 64'(err), 0);
        check("t6_rst_pend", 64'(pend_count), 0);

        // randomized traffic against the scoreboard
        do_reset();
        pend_model = 0;
        rand_en = 1;
        slave_run = 1;
        fork
            slave_loop();
        join_none
        fork
            run_master(0, 40);
            run_master(1, 40);
        join
        for (int t = 0; t < 500 && ret_q.size() > 0; t++) next_cycle();
        repeat (3) next_cycle();
        slave_run = 0;
        repeat (3) next_cycle();
        rand_en = 0;
        check("final_exp_q0", 64'(exp_q0.size()), 0);
        check("final_exp_q1", 64'(exp_q1.size()), 0);
        check("final_exp_rd_q", 64'(exp_rd_q.size()), 0);
        check("final_pend", 64'(pend_count), 0);
        check("final_err", 64'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
